// File: rtl/pc_fetch_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_if
//
// Groups the fetch-sequencer control inputs and status outputs into a single
// bundle shared by the sequencer and the pipeline/debug logic around it.
//
// Signals:
//   stall           - hold the current PC; the same fetch is re-presented
//   redirect        - taken branch or jump from execute
//   redirect_target - new PC when redirect is set
//   halt            - stop fetching until reset
//   pc              - current fetch PC (registered), feeds shiftLPC
//   pc_seq          - pc + 1 modulo 2^PC_WIDTH (combinational link value)
//   fetch_valid     - pc is a real fetch this cycle
//   halted          - sequencer is halted
//   wrapped         - sticky: the PC has incremented from all-ones to zero
//   fetch_count     - saturating count of accepted fetches
//
// Modports:
//   master - the pipeline/control side: drives the controls, reads the status
//   slave  - the sequencer: reads the controls, drives the PC and status
// ----------------------------------------------------------------------------
interface pc_fetch_if #(
    parameter int PC_WIDTH = 12
);
    logic                stall;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                halt;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_seq;
    logic                fetch_valid;
    logic                halted;
    logic                wrapped;
    logic [15:0]         fetch_count;

    modport master (
        output stall,
        output redirect,
        output redirect_target,
        output halt,
        input  pc,
        input  pc_seq,
        input  fetch_valid,
        input  halted,
        input  wrapped,
        input  fetch_count
    );

    modport slave (
        input  stall,
        input  redirect,
        input  redirect_target,
        input  halt,
        output pc,
        output pc_seq,
        output fetch_valid,
        output halted,
        output wrapped,
        output fetch_count
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Program-counter sequencer for the fetch stage. Holds the word-index PC,
// advances it on every accepted fetch and applies redirects, stalls and halt.
// The PC feeds the shiftLPC address-expansion stage; fetch-valid, wrap and
// fetch-count status go to decode and debug.
//
// Parameters:
//   PC_WIDTH - PC width in bits (must match the shiftLPC input)
//   RESET_PC - value loaded into pc on reset
//
// Ports:
//   clk - single clock, all state updates on the rising edge
//   rst - synchronous active-high reset
//   bus - pc_fetch_if slave modport (controls in, PC and status out)
//
// Per-edge priority: rst > halt > redirect > stall > increment.
// ----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int                  PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst,
    pc_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,  // one cycle after reset, pc not yet a real fetch
        RUN    = 2'd1,  // normal fetching
        BUBBLE = 2'd2,  // one cycle after a redirect
        HALT   = 2'd3   // absorbing until reset
    } state_t;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    state_t              state;
    logic [PC_WIDTH-1:0] pc_q;
    logic                fetch_valid_q;
    logic                halted_q;
    logic                wrapped_q;
    logic [15:0]         fetch_count_q;
    logic [PC_WIDTH-1:0] pc_inc;

    // Link value and next sequential PC; modulo 2^PC_WIDTH by truncation.
    assign pc_inc = pc_q + 1'b1;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            wrapped_q     <= 1'b0;
            fetch_count_q <= '0;
        end else if (state == HALT) begin
            // Absorbing: pc, status and counters are frozen until reset.
            state <= HALT;
        end else if (bus.halt) begin
            // Halt overrides redirect and stall; pc freezes at its value.
            state         <= HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
        end else if (bus.redirect) begin
            // A redirect wins over stall; the fetch presented this cycle is
            // discarded and not counted. Loading zero never sets wrapped.
            state         <= BUBBLE;
            pc_q          <= bus.redirect_target;
            fetch_valid_q <= 1'b0;
        end else begin
            unique case (state)
                BOOT, BUBBLE: begin
                    // Proceed to RUN even when stalled; pc holds so the
                    // first RUN cycle fetches the reset/target address.
                    state         <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    if (!bus.stall) begin
                        pc_q <= pc_inc;
                        if (pc_q == {PC_WIDTH{1'b1}}) begin
                            wrapped_q <= 1'b1;
                        end
                        if (fetch_count_q != COUNT_MAX) begin
                            fetch_count_q <= fetch_count_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_seq      = pc_inc;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.wrapped     = wrapped_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Scoreboard bench for pc_fetch_sequencer. The driver applies one set of
// inputs per cycle, steps a behavioural model and pushes the expected
// post-edge outputs into a queue; the monitor pops and compares on every
// falling edge.
// ----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam int          W        = 12;
    localparam logic [W-1:0] RST_PC  = 12'h123;
    localparam int          PC_MOD   = 1 << W;

    typedef struct {
        int pc;
        int pc_seq;
        bit fetch_valid;
        bit halted;
        bit wrapped;
        int fetch_count;
    } exp_t;

    logic clk;
    logic rst;

    pc_fetch_if #(.PC_WIDTH(W)) bus ();

    pc_fetch_sequencer #(
        .PC_WIDTH (W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks whether the current pc is a real fetch, whether fetching has
    // stopped, and the unbounded number of accepted fetches.
    int m_pc;
    bit m_valid;
    bit m_halted;
    bit m_wrapped;
    int m_fetches;

    function automatic exp_t model_step(input bit r, input bit h, input bit rd,
                                        input int t, input bit s);
        exp_t e;
        if (r) begin
            m_pc = RST_PC; m_valid = 0; m_halted = 0; m_wrapped = 0; m_fetches = 0;
        end else if (m_halted) begin
            // nothing moves
        end else if (h) begin
            m_halted = 1; m_valid = 0;
        end else if (rd) begin
            m_pc = t; m_valid = 0;
        end else if (!m_valid) begin
            m_valid = 1;
        end else if (!s) begin
            m_fetches++;
            if (m_pc == PC_MOD - 1) m_wrapped = 1;
            m_pc = (m_pc + 1) % PC_MOD;
        end
        e.pc          = m_pc;
        e.pc_seq      = (m_pc + 1) % PC_MOD;
        e.fetch_valid = m_valid;
        e.halted      = m_halted;
        e.wrapped     = m_wrapped;
        e.fetch_count = (m_fetches > 65535) ? 65535 : m_fetches;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input bit h, input bit rd,
                         input logic [W-1:0] t, input bit s);
        rst                 = r;
        bus.halt            = h;
        bus.redirect        = rd;
        bus.redirect_target = t;
        bus.stall           = s;
        sb.push_back(model_step(r, h, rd, int'(t), s));
        @(negedge clk);
        #1;
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pc",          int'(bus.pc),          e.pc);
            check("pc_seq",      int'(bus.pc_seq),      e.pc_seq);
            check("fetch_valid", int'(bus.fetch_valid), int'(e.fetch_valid));
            check("halted",      int'(bus.halted),      int'(e.halted));
            check("wrapped",     int'(bus.wrapped),     int'(e.wrapped));
            check("fetch_count", int'(bus.fetch_count), e.fetch_count);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit r, h, rd, s;
        logic [W-1:0] t;

        // Reset and run.
        cycle(1, 0, 0, '0, 0);
        free(4);

        // Stall at ABC for two cycles, then release.
        cycle(0, 0, 1, 12'hABC, 0);
        free(1);
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 1);
        free(2);

        // Redirect to zero with a simultaneous stall.
        cycle(0, 0, 1, 12'h000, 1);
        free(2);

        // Wrap, then a later redirect keeps wrapped set.
        cycle(0, 0, 1, 12'hFFF, 0);
        free(2);
        cycle(0, 0, 1, 12'h200, 0);
        cycle(0, 0, 1, 12'h300, 1);   // redirect while in BUBBLE
        free(2);

        // Halt and redirect on the same edge at pc=010.
        cycle(0, 0, 1, 12'h010, 0);
        free(1);
        cycle(0, 1, 1, 12'h055, 0);
        for (int i = 0; i < 10; i++)
            cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom), 1'($urandom_range(0, 1)));
        cycle(1, 0, 0, '0, 0);
        free(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            h  = ($urandom_range(0, 99) < 2);
            rd = ($urandom_range(0, 99) < 15);
            s  = ($urandom_range(0, 99) < 25);
            t  = ($urandom_range(0, 3) == 0) ? W'(12'hFFC + $urandom_range(0, 3))
                                             : W'($urandom);
            cycle(r, h, rd, t, s);
        end

        // Count saturation over an uninterrupted run.
        cycle(1, 0, 0, '0, 0);
        free(65541);

        // Drain: give the monitor a bounded number of edges.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Program-counter sequencer for the fetch stage. Holds the 12-bit word-index PC, advances it each accepted fetch, and applies branch/jump redirects, pipeline stalls and halt. Produces the `pc` consumed by the shiftLPC address-expansion stage, which widens it to the 16-bit memory address. Also provides fetch-valid, wrap and fetch-count status to the decode stage and the debug logic.

## Interface
- `PC_WIDTH`, default 12: PC width in bits; must match the shiftLPC input.
- `RESET_PC`, default 12'h000: value loaded into `pc` on reset.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: reset; synchronous and active-high.
- `stall` input, 1: hold the current PC; the same fetch is re-presented.
- `redirect` input, 1: taken branch or jump from execute.
- `redirect_target` input, PC_WIDTH: new PC when `redirect`=1.
- `halt` input, 1: stop fetching permanently until reset.
- `pc` output, PC_WIDTH: current fetch PC, registered; feeds shiftLPC.
- `pc_seq` output, PC_WIDTH: `pc`+1 modulo 2^PC_WIDTH, combinational; the link value.
- `fetch_valid` output, 1: `pc` is a real fetch this cycle.
- `halted` output, 1: sequencer is in HALT.
- `wrapped` output, 1: sticky flag; the PC has wrapped from all-ones to zero.
- `fetch_count` output, 16: number of accepted fetches; saturating.

## Operation
- There are four states:
  - BOOT: after reset, for one cycle.
  - RUN: normal fetching.
  - BUBBLE: one cycle after a redirect.
  - HALT: absorbing.
- Outputs by state:
  - `fetch_valid` = 1 only in RUN.
  - `halted` = 1 only in HALT.
- Per-edge priority is `rst` > `halt` > `redirect` > `stall` > increment.
- `rst`: sets `pc`=RESET_PC and state=BOOT. Clears `wrapped` and `fetch_count`.
- `halt` (any non-reset state): next state is HALT and `pc` is frozen. `redirect` and `stall` are ignored. Only `rst` leaves HALT.
- `redirect` (in BOOT, RUN or BUBBLE): sets `pc`=`redirect_target` and next state=BUBBLE.
  - A redirect while already in BUBBLE reloads the target and stays in BUBBLE.
  - The fetch presented in the redirect cycle is not counted.
- `stall` with no redirect:
  - `pc` holds and the state is unchanged, except BOOT→RUN and BUBBLE→RUN, which proceed regardless of stall.
  - `fetch_count` does not change.
- Increment (RUN, no stall/redirect/halt): `pc` ← `pc_seq`, and `fetch_count` is incremented.
- In BOOT and BUBBLE with no redirect: `pc` holds and the next state is RUN.
- An accepted fetch is `fetch_valid` & !`stall` & !`redirect` & !`halt`.
- Arithmetic and width rules:
  - `pc` arithmetic is modulo 2^PC_WIDTH.
  - Incrementing from all-ones gives zero and sets `wrapped`. It stays set until `rst`.
  - A redirect to zero does not set `wrapped`.
  - `fetch_count` saturates at 16'hFFFF.

## Timing
- Reset values: `pc`=RESET_PC, `fetch_valid`=0, `halted`=0, `wrapped`=0, `fetch_count`=0, state=BOOT.
- Latency:
  - After `rst` is released, `fetch_valid` rises one cycle later and the first RUN cycle presents RESET_PC.
  - A redirect sampled at edge N gives `pc`=target after N with `fetch_valid`=0 for that cycle. At edge N+1 the state is RUN and target is fetched. At edge N+2 `pc`=target+1, unless stalled.
  - `halt` sampled at edge N gives `halted`=1 and `fetch_valid`=0 after N.
- `pc` and all status outputs are registered; `pc_seq` is the only combinational output.
- Reset mid-operation (any state, including HALT) takes effect at the next edge. Nothing partial is retained.

## Test plan
- Reset and run: RESET_PC=12'h123, `rst` for 1 cycle, then 4 free cycles.
  - Required: `pc`=123 with `fetch_valid`=0 for the BOOT cycle.
  - Then `pc`=123, 124, 125 with `fetch_valid`=1 and `fetch_count`=2 after the third RUN cycle.
- Stall: at `pc`=12'hABC, `stall`=1 for 2 cycles.
  - Required: `pc` stays ABC, `fetch_valid`=1, `fetch_count` unchanged.
  - After release: ABD on the next edge.
- Redirect with simultaneous stall: `redirect`=1, `redirect_target`=12'h000, `stall`=1 in RUN.
  - Required: `pc`=000 with `fetch_valid`=0 for one cycle.
  - Then `pc`=000 valid, then 001 on the next edge; `wrapped` stays 0.
- Wrap: redirect to 12'hFFF, then 2 free RUN cycles.
  - Required: `pc`=FFF, then 000 with `wrapped`=1 and `pc_seq`=001.
  - `wrapped` stays 1 through later redirects.
- Halt vs redirect: `halt`=1 and `redirect`=1 (target 12'h055) on the same edge at `pc`=12'h010.
  - Required: `pc` stays 010, `halted`=1, `fetch_valid`=0, held for 10 cycles.
  - `rst` then gives `pc`=RESET_PC, `halted`=0, `wrapped`=0, `fetch_count`=0.
- Count saturation: 65540 uninterrupted RUN cycles.
  - Required: `fetch_count`=16'hFFFF, holding at that value while `pc` continues to wrap.
